regfile_rename: RTL and testbench
=================================

Name: regfile_rename

Overview:
- Architectural register file plus per-register rename status (busy bit and ROB tag).
- Sits at the commit end of the ROB. Consumes the ROB's in-order commit stream (destination register, tag, value) and the dispatch-time rename requests.
- Serves two operand lookups per cycle to dispatch. Each lookup returns either a ready value or the ROB tag the consumer must wait on.
- Flush clears all pending renames on branch mispredict.

Parameters:
REG_NUM, 32, number of architectural registers (x0 hardwired zero)
TAG_W, 4, ROB tag width; tag 0 is reserved for "no producer"

Ports:
clk_in  input  1  clock, rising edge
rst_in  input  1  asynchronous, active-low reset
rdy_in  input  1  global ready; low freezes all state
issue_valid  input  1  rename request from dispatch this cycle
issue_rd  input  5  destination register being renamed
issue_tag  input  TAG_W  ROB tag of the new producer
commit_valid  input  1  ROB commit of a register-writing instruction (destType reg or jump-and-link)
commit_rd  input  5  committed destination register
commit_tag  input  TAG_W  ROB tag of the committing entry
commit_value  input  32  committed result
flush_in  input  1  mispredict flush
rs1_idx  input  5  lookup index, port 1
rs1_val  output  32  register value, port 1
rs1_busy  output  1  1 = value pending, wait on rs1_tag
rs1_tag  output  TAG_W  producer tag (0 when not busy)
rs2_idx, rs2_val, rs2_busy, rs2_tag  same as port 1
commit_cnt  output  32  count of accepted commits (perf counter)

Behaviour:
- Reset (rst_in low, asynchronous): all registers 0, all busy 0, all tags 0, commit_cnt 0. Lookup outputs therefore read val 0, busy 0, tag 0.
- rdy_in low: no state updates. Lookups remain combinational on the current state.
- Lookup ports are combinational with 0-cycle latency. When busy=0, tag reads 0.
- x0:
  - Always reads val 0, busy 0, tag 0.
  - Issue and commit targeting x0 are ignored. commit_cnt still increments on a commit to x0.
- Issue (issue_valid, rd != 0): on the next edge, busy[rd] <= 1 and tag[rd] <= issue_tag.
- Commit (commit_valid, rd != 0):
  - On the next edge, reg[rd] <= commit_value unconditionally.
  - busy[rd] clears only if busy[rd]=1 and tag[rd]==commit_tag. A younger rename must survive.
  - commit_cnt increments by 1 and wraps at 2^32.
- Same-cycle issue and commit to the same rd: value is written; busy stays 1 with issue_tag (issue wins).
- Flush:
  - On the next edge, all busy bits are cleared and all tags reset to 0. Register values are kept.
  - A commit in the same cycle still writes its value and counts.
  - An issue in the same cycle is dropped (flush wins).
- Lookups in the same cycle as an issue do not see the new rename. Dispatch handles intra-bundle dependence.

Optional Feature:
- REGFILE_BYPASS_EN defined: commit-to-lookup bypass. If commit_valid, commit_rd == rsX_idx != 0, busy[rd]=1 and tag[rd]==commit_tag, the lookup returns val=commit_value, busy=0, tag=0 in the same cycle.
- REGFILE_BYPASS_EN undefined: lookups see registered state only. The consumer sees the value one cycle after commit and must snoop the CDB for it.

Decomposition:
- REG_NUM, TAG_W default, and the "no producer" tag constant belong in the shared define.v include, alongside the ROB opcode/destType encodings.
- One natural sub-module: regfile_lookup, the per-port combinational read/bypass mux, instantiated twice. Storage, rename, commit, and counter logic stay in the top.

Test Plan:
- Reset then read x5 on both ports -> val 0, busy 0, tag 0, commit_cnt 0.
- Issue x5 tag 3; next cycle read x5 -> busy 1, tag 3. Commit x5 tag 3 value 0xDEADBEEF; next cycle -> val 0xDEADBEEF, busy 0, commit_cnt 1.
- Issue x7 tag 2, then issue x7 tag 4, then commit x7 tag 2 value 0x11 -> val 0x11, busy 1, tag 4. Then commit tag 4 value 0x22 -> val 0x22, busy 0.
- Same-cycle issue x9 tag 6 and commit x9 tag 5 value 0x55 (x9 previously tag 5) -> val 0x55, busy 1, tag 6.
- Rename x1..x3, then flush with a concurrent commit x1 -> all busy 0, x1 holds the committed value, x2 and x3 keep their old values. A concurrent issue is dropped.
- Issue/commit to x0 with value 0xFFFFFFFF -> x0 reads 0, not busy, commit_cnt increments. With REGFILE_BYPASS_EN, a commit of x5 tag 3 value 0x77 shows on rs1_val the same cycle with busy 0.

Source files
------------

// File: rtl/regfile_rename_pkg.sv
// Shared definitions for the architectural register file / rename status block:
// default geometry, the "no producer" tag, and ROB encodings used alongside it.
package regfile_rename_pkg;

  localparam int REG_NUM_DEF = 32;
  localparam int TAG_W_DEF   = 4;
  localparam int IDX_W       = 5;
  localparam int XLEN        = 32;

  // Tag value meaning "no in-flight producer"; real ROB entries never use it.
  localparam logic [TAG_W_DEF-1:0] NO_TAG = '0;

  // ROB destination type of an entry.
  typedef enum logic [1:0] {
    DEST_NONE = 2'd0,
    DEST_REG  = 2'd1,
    DEST_MEM  = 2'd2,
    DEST_JAL  = 2'd3
  } dest_type_e;

  // Coarse ROB opcode classes.
  typedef enum logic [2:0] {
    ROB_OP_ALU    = 3'd0,
    ROB_OP_LOAD   = 3'd1,
    ROB_OP_STORE  = 3'd2,
    ROB_OP_BRANCH = 3'd3,
    ROB_OP_JAL    = 3'd4,
    ROB_OP_JALR   = 3'd5
  } rob_op_e;

endpackage

// File: rtl/regfile_rename_lookup.sv
// One combinational operand read port: selects value/busy/tag for an index,
// forces x0 to zero and hides stale tags of non-busy registers.
// With REGFILE_BYPASS_EN defined, a matching commit this cycle is forwarded.
module regfile_rename_lookup
  import regfile_rename_pkg::*;
#(
  parameter int REG_NUM = REG_NUM_DEF,
  parameter int TAG_W   = TAG_W_DEF
) (
  input  logic [IDX_W-1:0]                idx,
  input  logic [REG_NUM-1:0][XLEN-1:0]    reg_vals,
  input  logic [REG_NUM-1:0]              reg_busy,
  input  logic [REG_NUM-1:0][TAG_W-1:0]   reg_tags,
`ifdef REGFILE_BYPASS_EN
  input  logic                            commit_valid,
  input  logic [IDX_W-1:0]                commit_rd,
  input  logic [TAG_W-1:0]                commit_tag,
  input  logic [XLEN-1:0]                 commit_value,
`endif
  output logic [XLEN-1:0]                 rd_val,
  output logic                            rd_busy,
  output logic [TAG_W-1:0]                rd_tag
);

  // Read mux with x0 and not-busy masking, optionally overridden by a commit.
  always_comb begin
    rd_val  = reg_vals[idx];
    rd_busy = reg_busy[idx];
    rd_tag  = reg_tags[idx];
    if (idx == '0) begin
      rd_val  = '0;
      rd_busy = 1'b0;
    end
    if (!rd_busy) begin
      rd_tag = TAG_W'(NO_TAG);
    end
`ifdef REGFILE_BYPASS_EN
    if (commit_valid && (commit_rd == idx) && (idx != '0) &&
        reg_busy[idx] && (reg_tags[idx] == commit_tag)) begin
      rd_val  = commit_value;
      rd_busy = 1'b0;
      rd_tag  = TAG_W'(NO_TAG);
    end
`endif
  end

endmodule

// File: rtl/regfile_rename.sv
// Architectural register file with per-register rename status (busy + ROB tag).
// Takes in-order commits from the ROB and rename requests from dispatch, and
// serves two combinational operand lookups. Optional macro: REGFILE_BYPASS_EN
// forwards a same-cycle commit to the lookup ports.
module regfile_rename
  import regfile_rename_pkg::*;
#(
  parameter int REG_NUM = REG_NUM_DEF,
  parameter int TAG_W   = TAG_W_DEF
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              issue_valid,
  input  logic [IDX_W-1:0]  issue_rd,
  input  logic [TAG_W-1:0]  issue_tag,
  input  logic              commit_valid,
  input  logic [IDX_W-1:0]  commit_rd,
  input  logic [TAG_W-1:0]  commit_tag,
  input  logic [XLEN-1:0]   commit_value,
  input  logic              flush_in,
  input  logic [IDX_W-1:0]  rs1_idx,
  output logic [XLEN-1:0]   rs1_val,
  output logic              rs1_busy,
  output logic [TAG_W-1:0]  rs1_tag,
  input  logic [IDX_W-1:0]  rs2_idx,
  output logic [XLEN-1:0]   rs2_val,
  output logic              rs2_busy,
  output logic [TAG_W-1:0]  rs2_tag,
  output logic [XLEN-1:0]   commit_cnt
);

  logic [REG_NUM-1:0][XLEN-1:0]  regs_q, regs_d;
  logic [REG_NUM-1:0]            busy_q, busy_d;
  logic [REG_NUM-1:0][TAG_W-1:0] tags_q, tags_d;
  logic [XLEN-1:0]               cnt_q, cnt_d;

  // Next state: commit writes value and retires a matching rename; flush
  // wipes rename state and beats a concurrent issue; an issue otherwise
  // overrides the retire of the same register. x0 is never written.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    tags_d = tags_q;
    cnt_d  = cnt_q;
    if (rdy_in) begin
      if (commit_valid) begin
        cnt_d = cnt_q + 32'd1;
        if (commit_rd != '0) begin
          regs_d[commit_rd] = commit_value;
          if (busy_q[commit_rd] && (tags_q[commit_rd] == commit_tag)) begin
            busy_d[commit_rd] = 1'b0;
            tags_d[commit_rd] = TAG_W'(NO_TAG);
          end
        end
      end
      if (flush_in) begin
        busy_d = '0;
        tags_d = '0;
      end else if (issue_valid && (issue_rd != '0)) begin
        busy_d[issue_rd] = 1'b1;
        tags_d[issue_rd] = issue_tag;
      end
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      regs_q <= '0;
      busy_q <= '0;
      tags_q <= '0;
      cnt_q  <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
      tags_q <= tags_d;
      cnt_q  <= cnt_d;
    end
  end

  assign commit_cnt = cnt_q;

  regfile_rename_lookup #(.REG_NUM(REG_NUM), .TAG_W(TAG_W)) u_lookup_rs1 (
    .idx          (rs1_idx),
    .reg_vals     (regs_q),
    .reg_busy     (busy_q),
    .reg_tags     (tags_q),
`ifdef REGFILE_BYPASS_EN
    .commit_valid (commit_valid),
    .commit_rd    (commit_rd),
    .commit_tag   (commit_tag),
    .commit_value (commit_value),
`endif
    .rd_val       (rs1_val),
    .rd_busy      (rs1_busy),
    .rd_tag       (rs1_tag)
  );

  regfile_rename_lookup #(.REG_NUM(REG_NUM), .TAG_W(TAG_W)) u_lookup_rs2 (
    .idx          (rs2_idx),
    .reg_vals     (regs_q),
    .reg_busy     (busy_q),
    .reg_tags     (tags_q),
`ifdef REGFILE_BYPASS_EN
    .commit_valid (commit_valid),
    .commit_rd    (commit_rd),
    .commit_tag   (commit_tag),
    .commit_value (commit_value),
`endif
    .rd_val       (rs2_val),
    .rd_busy      (rs2_busy),
    .rd_tag       (rs2_tag)
  );

endmodule

// File: tb/tb_regfile_rename.sv
// Directed bench for regfile_rename: expectations are queued as stimulus is
// driven and compared against the lookup ports and commit counter.
module tb_regfile_rename;

  logic        clk_in;
  logic        rst_in;
  logic        rdy_in;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [3:0]  issue_tag;
  logic        commit_valid;
  logic [4:0]  commit_rd;
  logic [3:0]  commit_tag;
  logic [31:0] commit_value;
  logic        flush_in;
  logic [4:0]  rs1_idx;
  logic [31:0] rs1_val;
  logic        rs1_busy;
  logic [3:0]  rs1_tag;
  logic [4:0]  rs2_idx;
  logic [31:0] rs2_val;
  logic        rs2_busy;
  logic [3:0]  rs2_tag;
  logic [31:0] commit_cnt;

  regfile_rename dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .rdy_in       (rdy_in),
    .issue_valid  (issue_valid),
    .issue_rd     (issue_rd),
    .issue_tag    (issue_tag),
    .commit_valid (commit_valid),
    .commit_rd    (commit_rd),
    .commit_tag   (commit_tag),
    .commit_value (commit_value),
    .flush_in     (flush_in),
    .rs1_idx      (rs1_idx),
    .rs1_val      (rs1_val),
    .rs1_busy     (rs1_busy),
    .rs1_tag      (rs1_tag),
    .rs2_idx      (rs2_idx),
    .rs2_val      (rs2_val),
    .rs2_busy     (rs2_busy),
    .rs2_tag      (rs2_tag),
    .commit_cnt   (commit_cnt)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [4:0]  i1;
    logic [31:0] v1;
    logic        b1;
    logic [3:0]  t1;
    logic [4:0]  i2;
    logic [31:0] v2;
    logic        b2;
    logic [3:0]  t2;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb_q[$];
  string       name_q[$];
  int          total  = 0;
  int          passed = 0;
  int          fails  = 0;
  logic [31:0] exp_cnt = 0;

  task automatic cmp(input string nm, input string fld,
                     input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s %s got %h expected %h", nm, fld, got, exp);
    end
  endtask

  task automatic expect2(input string nm,
                         input logic [4:0] i1, input logic [31:0] v1,
                         input logic b1, input logic [3:0] t1,
                         input logic [4:0] i2, input logic [31:0] v2,
                         input logic b2, input logic [3:0] t2);
    exp_t e;
    e.i1 = i1; e.v1 = v1; e.b1 = b1; e.t1 = t1;
    e.i2 = i2; e.v2 = v2; e.b2 = b2; e.t2 = t2;
    e.cnt = exp_cnt;
    sb_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic expect1(input string nm, input logic [4:0] i,
                         input logic [31:0] v, input logic b,
                         input logic [3:0] t);
    expect2(nm, i, v, b, t, i, v, b, t);
  endtask

  // Pop every queued expectation, steer the lookup ports and compare.
  task automatic check_all();
    exp_t  e;
    string nm;
    while (sb_q.size() > 0) begin
      e  = sb_q.pop_front();
      nm = name_q.pop_front();
      rs1_idx = e.i1;
      rs2_idx = e.i2;
      #1;
      cmp(nm, "rs1_val",    rs1_val,           e.v1);
      cmp(nm, "rs1_busy",   {31'd0, rs1_busy}, {31'd0, e.b1});
      cmp(nm, "rs1_tag",    {28'd0, rs1_tag},  {28'd0, e.t1});
      cmp(nm, "rs2_val",    rs2_val,           e.v2);
      cmp(nm, "rs2_busy",   {31'd0, rs2_busy}, {31'd0, e.b2});
      cmp(nm, "rs2_tag",    {28'd0, rs2_tag},  {28'd0, e.t2});
      cmp(nm, "commit_cnt", commit_cnt,        e.cnt);
    end
  endtask

  task automatic idle();
    issue_valid  = 1'b0;
    issue_rd     = '0;
    issue_tag    = '0;
    commit_valid = 1'b0;
    commit_rd    = '0;
    commit_tag   = '0;
    commit_value = '0;
    flush_in     = 1'b0;
  endtask

  task automatic tick();
    if (rdy_in && rst_in && commit_valid) exp_cnt = exp_cnt + 32'd1;
    @(posedge clk_in);
    #1;
    idle();
  endtask

  task automatic issue(input logic [4:0] rd, input logic [3:0] tag);
    issue_valid = 1'b1;
    issue_rd    = rd;
    issue_tag   = tag;
  endtask

  task automatic commit(input logic [4:0] rd, input logic [3:0] tag,
                        input logic [31:0] val);
    commit_valid = 1'b1;
    commit_rd    = rd;
    commit_tag   = tag;
    commit_value = val;
  endtask

  initial begin
    rst_in  = 1'b0;
    rdy_in  = 1'b1;
    rs1_idx = '0;
    rs2_idx = '0;
    idle();
    repeat (2) @(posedge clk_in);
    #1;
    expect1("reset_x5", 5'd5, 32'h0, 1'b0, 4'd0);
    check_all();
    @(negedge clk_in);
    rst_in = 1'b1;

    // Rename x5 with tag 3; the lookup in the issue cycle must not see it.
    issue(5'd5, 4'd3);
    expect1("issue_not_visible", 5'd5, 32'h0, 1'b0, 4'd0);
    check_all();
    tick();
    expect1("x5_renamed", 5'd5, 32'h0, 1'b1, 4'd3);
    check_all();

    // Commit x5 tag 3.
    commit(5'd5, 4'd3, 32'hDEADBEEF);
`ifdef REGFILE_BYPASS_EN
    expect1("x5_commit_cycle", 5'd5, 32'hDEADBEEF, 1'b0, 4'd0);
`else
    expect1("x5_commit_cycle", 5'd5, 32'h0, 1'b1, 4'd3);
`endif
    check_all();
    tick();
    expect1("x5_committed", 5'd5, 32'hDEADBEEF, 1'b0, 4'd0);
    check_all();

    // Younger rename of x7 survives the older commit.
    issue(5'd7, 4'd2);
    tick();
    issue(5'd7, 4'd4);
    tick();
    commit(5'd7, 4'd2, 32'h11);
    tick();
    expect1("x7_older_commit", 5'd7, 32'h11, 1'b1, 4'd4);
    check_all();
    commit(5'd7, 4'd4, 32'h22);
    tick();
    expect1("x7_younger_commit", 5'd7, 32'h22, 1'b0, 4'd0);
    check_all();

    // Same-cycle issue and commit on x9: issue wins the rename state.
    issue(5'd9, 4'd5);
    tick();
    issue(5'd9, 4'd6);
    commit(5'd9, 4'd5, 32'h55);
    tick();
    expect1("x9_issue_commit", 5'd9, 32'h55, 1'b1, 4'd6);
    check_all();

    // Commit with a non-matching tag writes the value but keeps the rename.
    issue(5'd10, 4'd8);
    tick();
    commit(5'd10, 4'd9, 32'hAB);
    expect1("x10_mismatch_cycle", 5'd10, 32'h0, 1'b1, 4'd8);
    check_all();
    tick();
    expect1("x10_stale_commit", 5'd10, 32'hAB, 1'b1, 4'd8);
    check_all();

    // Give x2/x3 values, rename x1..x3, then flush with a commit and issue.
    commit(5'd2, 4'd0, 32'hA2);
    tick();
    commit(5'd3, 4'd0, 32'hA3);
    tick();
    issue(5'd1, 4'd1);
    tick();
    issue(5'd2, 4'd2);
    tick();
    issue(5'd3, 4'd3);
    tick();
    expect2("pre_flush", 5'd1, 32'h0, 1'b1, 4'd1, 5'd3, 32'hA3, 1'b1, 4'd3);
    check_all();
    flush_in = 1'b1;
    commit(5'd1, 4'd1, 32'h1111);
    issue(5'd4, 4'd7);
    tick();
    expect2("flush_x1_x2", 5'd1, 32'h1111, 1'b0, 4'd0, 5'd2, 32'hA2, 1'b0, 4'd0);
    expect2("flush_x3_x4", 5'd3, 32'hA3, 1'b0, 4'd0, 5'd4, 32'h0, 1'b0, 4'd0);
    expect2("flush_x9_x10", 5'd9, 32'h55, 1'b0, 4'd0, 5'd10, 32'hAB, 1'b0, 4'd0);
    check_all();

    // x0 ignores issue and commit; the counter still advances.
    issue(5'd0, 4'd5);
    commit(5'd0, 4'd0, 32'hFFFFFFFF);
    tick();
    expect2("x0_ignored", 5'd0, 32'h0, 1'b0, 4'd0, 5'd5, 32'hDEADBEEF, 1'b0, 4'd0);
    check_all();

    // rdy_in low freezes everything.
    rdy_in = 1'b0;
    issue(5'd6, 4'd1);
    commit(5'd7, 4'd0, 32'h66);
    tick();
    rdy_in = 1'b1;
    expect2("rdy_low_frozen", 5'd6, 32'h0, 1'b0, 4'd0, 5'd7, 32'h22, 1'b0, 4'd0);
    check_all();

    // Commit of x5 tag 3 value 0x77 against a live rename.
    issue(5'd5, 4'd3);
    tick();
    commit(5'd5, 4'd3, 32'h77);
`ifdef REGFILE_BYPASS_EN
    expect1("x5_bypass_cycle", 5'd5, 32'h77, 1'b0, 4'd0);
`else
    expect1("x5_bypass_cycle", 5'd5, 32'hDEADBEEF, 1'b1, 4'd3);
`endif
    check_all();
    tick();
    expect1("x5_after_bypass", 5'd5, 32'h77, 1'b0, 4'd0);
    check_all();

    // Asynchronous reset mid-cycle clears state immediately.
    issue(5'd8, 4'd2);
    tick();
    #2;
    rst_in  = 1'b0;
    exp_cnt = 0;
    idle();
    expect2("async_reset", 5'd5, 32'h0, 1'b0, 4'd0, 5'd8, 32'h0, 1'b0, 4'd0);
    check_all();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
